// File: rtl/if_id_skid_reg_pkg.sv
// rv32i_pipe_pkg: shared types and constants for the RV32I pipeline stage registers.
//   NOP_INSTR     - canonical bubble instruction (addi x0,x0,0)
//   skid_state_e  - occupancy of a two-slot skid register
//   fetch_beat_t  - IF/ID payload template at default widths, for other stage registers
package rv32i_pipe_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        MAIN  = 2'd1,
        SKID  = 2'd2
    } skid_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_plus_4;
        logic [31:0] instr;
        logic [0:0]  sb;
    } fetch_beat_t;

endpackage

// File: rtl/if_id_skid_reg_if.sv
// if_id_skid_reg_if: fetch-to-decode handshake bundle.
//   in_*  : upstream beat offered by fetch (in_ready flows back)
//   out_* : downstream beat offered to decode (out_ready flows back)
//   master: the side that drives fetch beats and decode ready
//   slave : the skid register itself
interface if_id_skid_reg_if #(
    parameter int XLEN = 32,
    parameter int ILEN = 32,
    parameter int SB_W = 1
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [ILEN-1:0] in_instr;
    logic [SB_W-1:0] in_sb;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_pc_plus_4;
    logic [ILEN-1:0] out_instr;
    logic [SB_W-1:0] out_sb;

    modport master (
        output in_valid, in_pc, in_instr, in_sb, out_ready,
        input  in_ready, out_valid, out_pc, out_pc_plus_4, out_instr, out_sb
    );

    modport slave (
        input  in_valid, in_pc, in_instr, in_sb, out_ready,
        output in_ready, out_valid, out_pc, out_pc_plus_4, out_instr, out_sb
    );
endinterface

// File: rtl/if_id_skid_reg_pipe_slot.sv
// pipe_slot: W-bit payload register with load enable and async active-low clear.
//   clk, rst_n : clock, async clear to zero
//   load       : capture d on the rising edge
//   d, q       : payload in / held payload
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    q <= '0;
        else if (load) q <= d;
    end
endmodule

// File: rtl/if_id_skid_reg.sv
// if_id_skid_reg: IF/ID pipeline register with valid/ready handshake, one-entry
// skid buffer and synchronous flush.
//   clk, rst_n : clock, async active-low reset
//   flush      : squash every held and incoming beat (redirect)
//   bus        : fetch-side in_* and decode-side out_* handshake
// Outputs always come from the main slot; the skid slot only absorbs the one
// beat that arrives in the cycle decode stalls. in_ready/out_valid decode the
// state register only, so there is no combinational ready or data path.
module if_id_skid_reg #(
    parameter int              XLEN      = 32,
    parameter int              ILEN      = 32,
    parameter int              SB_W      = 1,
    parameter logic [ILEN-1:0] NOP_INSTR = ILEN'(rv32i_pipe_pkg::NOP_INSTR)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    if_id_skid_reg_if.slave     bus
);
    import rv32i_pipe_pkg::*;

    localparam int W = 2*XLEN + ILEN + SB_W;

    skid_state_e state, state_n;
    logic        accept, take;
    logic        main_ld, skid_ld, main_from_skid;
    logic [W-1:0] in_beat, main_d, main_q, skid_q;

    logic [XLEN-1:0] m_pc, m_pc4;
    logic [ILEN-1:0] m_instr;
    logic [SB_W-1:0] m_sb;

    // pc+4 is taken at capture so decode never waits on the adder.
    assign in_beat = {bus.in_pc, bus.in_pc + XLEN'(4), bus.in_instr, bus.in_sb};
    assign main_d  = main_from_skid ? skid_q : in_beat;

    pipe_slot #(.W(W)) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (main_ld),
        .d     (main_d),
        .q     (main_q)
    );

    pipe_slot #(.W(W)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (skid_ld),
        .d     (in_beat),
        .q     (skid_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_n;
    end

    assign bus.in_ready  = (state != SKID);
    assign bus.out_valid = (state != EMPTY);
    assign accept        = bus.in_valid  && bus.in_ready;
    assign take          = bus.out_valid && bus.out_ready;

    always_comb begin
        state_n        = state;
        main_ld        = 1'b0;
        skid_ld        = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            // Anything accepted now is dropped; a take this cycle still counts.
            state_n = EMPTY;
        end else begin
            unique case (state)
                EMPTY: if (accept) begin
                    state_n = MAIN;
                    main_ld = 1'b1;
                end
                MAIN: begin
                    if (accept && take) begin
                        main_ld = 1'b1;
                    end else if (accept) begin
                        state_n = SKID;
                        skid_ld = 1'b1;
                    end else if (take) begin
                        state_n = EMPTY;
                    end
                end
                SKID: if (take) begin
                    state_n        = MAIN;
                    main_ld        = 1'b1;
                    main_from_skid = 1'b1;
                end
                default: state_n = EMPTY;
            endcase
        end
    end

    assign {m_pc, m_pc4, m_instr, m_sb} = main_q;

    assign bus.out_pc        = bus.out_valid ? m_pc    : '0;
    assign bus.out_pc_plus_4 = bus.out_valid ? m_pc4   : '0;
    assign bus.out_instr     = bus.out_valid ? m_instr : NOP_INSTR;
    assign bus.out_sb        = bus.out_valid ? m_sb    : '0;

endmodule

// File: doc/if_id_skid_reg.md
# if_id_skid_reg

Parametrised IF/ID pipeline register with a valid/ready handshake, a one-entry skid buffer, synchronous flush with NOP injection, and an asynchronous active-low reset. It sits between instruction fetch and decode. It replaces the plain clock-only IF/ID latch, so fetch can run ahead while decode stalls without losing a beat. A branch or jump redirect squashes everything in flight.

## Interface
Parameters:
- `XLEN`, 32, PC width in bits.
- `ILEN`, 32, instruction word width in bits.
- `SB_W`, 1, width of the opaque fetch sideband (e.g. a predicted-taken bit). Minimum 1.
- `NOP_INSTR`, 32'h0000_0013, instruction presented while the output is invalid or flushed (`addi x0,x0,0`).

Ports:
- `clk`, input, 1, rising-edge clock.
- `rst_n`, input, 1, asynchronous active-low reset. One clock domain; reset is asynchronous and active-low.
- `flush`, input, 1, synchronous squash of all held and incoming beats.
- `in_valid`, input, 1, fetch offers a beat.
- `in_ready`, output, 1, register can accept a beat. Registered.
- `in_pc`, input, XLEN, PC of the offered instruction.
- `in_instr`, input, ILEN, offered instruction word.
- `in_sb`, input, SB_W, offered sideband.
- `out_valid`, output, 1, decode beat valid. Registered.
- `out_ready`, input, 1, decode consumes the beat.
- `out_pc`, output, XLEN, PC of the held instruction.
- `out_pc_plus_4`, output, XLEN, `out_pc` + 4, modulo 2^XLEN.
- `out_instr`, output, ILEN, held instruction, or `NOP_INSTR` when invalid.
- `out_sb`, output, SB_W, held sideband, or 0 when invalid.

## Operation
Handshake events:
- An input beat is accepted when `in_valid && in_ready`.
- An output beat is taken when `out_valid && out_ready`.

State machine states:
- `EMPTY`: no beat held.
- `MAIN`: the main slot is valid.
- `SKID`: the main and skid slots are both valid.

Transitions, evaluated when `flush` = 0:
- `EMPTY`: accept → `MAIN`, main ← input.
- `MAIN`, accept and take: stay in `MAIN`, main ← input.
- `MAIN`, accept and no take: → `SKID`, skid ← input.
- `MAIN`, take and no accept: → `EMPTY`.
- `MAIN`, neither: hold.
- `SKID`, take: → `MAIN`, main ← skid. `in_ready` is 0 in `SKID`, so no accept can occur.

Flush:
- `flush` = 1 has priority over every other event and moves the state to `EMPTY` next cycle.
- A beat accepted in the flush cycle is dropped.
- A beat taken in the flush cycle counts as consumed; the flush does not un-take it.

Output and ready rules:
- `in_ready` = 1 in `EMPTY` and `MAIN`, 0 in `SKID`.
- Output fields always come from the main slot.
- When invalid, outputs read `pc` = 0, `instr` = `NOP_INSTR`, `sb` = 0.
- `pc_plus_4` is computed at capture (`in_pc` + 4, truncated to XLEN bits) and stored with the beat; it wraps, so 0xFFFF_FFFC → 0x0000_0000.
- Ordering is strict FIFO. No beat is duplicated or reordered.

## Timing
- Reset (asynchronous, `rst_n` = 0): `out_valid` = 0, `in_ready` = 1, `out_pc` = 0, `out_pc_plus_4` = 0, `out_instr` = `NOP_INSTR`, `out_sb` = 0, state = `EMPTY`, both slots cleared.
- Reset asserted mid-operation discards both slots immediately, regardless of the clock.
- After `rst_n` deasserts, the first accept can occur on the first rising edge.
- Latency: one cycle from accept to `out_valid`, in both `EMPTY` and `MAIN`.
- Throughput: one beat per cycle while `out_ready` = 1.
- `in_ready` falls the cycle after the skid slot fills and rises the cycle after the skid drains.
- No combinational path exists from `out_ready` to `in_ready`, or from `in_*` to `out_*`.
- Flush recovery: `out_valid` = 0 the cycle after `flush`. A new beat can be accepted in that same cycle and becomes visible one cycle later.

## Structure
- Package `rv32i_pipe_pkg` holds:
  - `NOP_INSTR` constant.
  - `skid_state_e` enum (`EMPTY`, `MAIN`, `SKID`).
  - A `fetch_beat_t` packed-struct template `{pc, pc_plus_4, instr, sb}`, at default widths, for the other stage registers.
- One sub-module is natural: `pipe_slot`, a parametrised payload register with load enable and async clear. It is instantiated twice, once for main and once for skid. The state machine and ready/valid logic stay in the top module.

## Test plan
- Reset and idle: hold `rst_n` = 0, then release with `in_valid` = 0. Outputs must stay `out_valid` = 0, `out_instr` = 0x0000_0013, `in_ready` = 1.
- Streaming: present PCs 0x100, 0x104, 0x108 on consecutive cycles with `out_ready` = 1. Outputs must appear one cycle later, in order, with `out_pc_plus_4` = 0x104, 0x108, 0x10C.
- Stall and skid: accept 0x200, then drop `out_ready` while 0x204 is offered. `in_ready` must go to 0. Raising `out_ready` must deliver 0x200 then 0x204, with no loss and no duplicate.
- Flush in `SKID` with a simultaneous offer: flush while both slots are full and `in_valid` = 1 with PC 0x300. Next cycle `out_valid` = 0 and `out_instr` = NOP. 0x300 must never appear at the output.
- Wrap-around: accept `in_pc` = 0xFFFF_FFFC. Output must show `out_pc_plus_4` = 0x0000_0000.
- Mid-stream async reset: assert `rst_n` between clock edges while in `SKID`. `out_valid` must drop immediately and the state returns to `EMPTY`.
